// File: rtl/vx_warp_ibuffer.sv
// Per-warp instruction buffer between decode and issue: one small FIFO per warp,
// round-robin selection of the warp presented downstream, and per-warp flush.
module vx_warp_ibuffer #(
    parameter  int NUM_WARPS = 4,
    parameter  int DEPTH     = 2,
    parameter  int DATAW     = 128,
    localparam int WIDW      = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WIDW-1:0]      in_wid,
    input  logic [DATAW-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [WIDW-1:0]      out_wid,
    output logic [DATAW-1:0]     out_data,
    input  logic                 out_ready,
    input  logic                 flush_valid,
    input  logic [WIDW-1:0]      flush_wid,
    output logic [NUM_WARPS-1:0] empty_mask
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    logic [DATAW-1:0]     mem    [NUM_WARPS][DEPTH];
    logic [PTRW-1:0]      wr_ptr [NUM_WARPS];
    logic [PTRW-1:0]      rd_ptr [NUM_WARPS];
    logic [CNTW-1:0]      count  [NUM_WARPS];

    logic [WIDW-1:0]      rr_ptr;
    logic                 hold;
    logic [WIDW-1:0]      held_wid;

    logic [NUM_WARPS-1:0] full_mask;
    logic [NUM_WARPS-1:0] flush_mask;
    logic [NUM_WARPS-1:0] eligible;
    logic [NUM_WARPS-1:0] push_sel;
    logic [NUM_WARPS-1:0] pop_sel;

    logic                 grant_valid;
    logic [WIDW-1:0]      grant_wid;
    logic [WIDW-1:0]      scan_wid;
    logic                 held_live;
    logic                 push;
    logic                 pop;

    always_comb begin
        full_mask  = '0;
        empty_mask = '0;
        flush_mask = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            full_mask[w]  = (count[w] == CNTW'(DEPTH));
            empty_mask[w] = (count[w] == '0);
            flush_mask[w] = flush_valid && (flush_wid == WIDW'(w));
        end
    end

    // A warp being flushed this cycle can neither be pushed nor presented.
    assign eligible = ~empty_mask & ~flush_mask;
    assign in_ready = !full_mask[in_wid] && !flush_mask[in_wid];

    always_comb begin
        grant_valid = 1'b0;
        grant_wid   = '0;
        scan_wid    = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            scan_wid = rr_ptr + WIDW'(i);
            if (!grant_valid && eligible[scan_wid]) begin
                grant_valid = 1'b1;
                grant_wid   = scan_wid;
            end
        end
    end

    // A stalled grant keeps priority over the scan until it is popped or flushed.
    assign held_live = hold && eligible[held_wid];
    assign out_valid = held_live || grant_valid;
    assign out_wid   = held_live ? held_wid : grant_wid;
    assign out_data  = mem[out_wid][rd_ptr[out_wid]];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        push_sel = '0;
        pop_sel  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            push_sel[w] = push && (in_wid == WIDW'(w));
            pop_sel[w]  = pop && (out_wid == WIDW'(w));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                wr_ptr[w] <= '0;
                rd_ptr[w] <= '0;
                count[w]  <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (flush_mask[w]) begin
                    wr_ptr[w] <= '0;
                    rd_ptr[w] <= '0;
                    count[w]  <= '0;
                end else begin
                    if (push_sel[w]) begin
                        wr_ptr[w] <= wr_ptr[w] + PTRW'(1);
                    end
                    if (pop_sel[w]) begin
                        rd_ptr[w] <= rd_ptr[w] + PTRW'(1);
                    end
                    if (push_sel[w] && !pop_sel[w]) begin
                        count[w] <= count[w] + CNTW'(1);
                    end else if (pop_sel[w] && !push_sel[w]) begin
                        count[w] <= count[w] - CNTW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= '0;
            hold     <= 1'b0;
            held_wid <= '0;
        end else begin
            if (pop) begin
                rr_ptr <= out_wid + WIDW'(1);
            end
            if (pop) begin
                hold <= 1'b0;
            end else if (out_valid) begin
                hold     <= 1'b1;
                held_wid <= out_wid;
            end else begin
                hold <= 1'b0;
            end
        end
    end

    // Payload storage is deliberately left unreset; empty slots are never presented.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[in_wid][wr_ptr[in_wid]] <= in_data;
        end
    end

endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// Directed self-checking bench for vx_warp_ibuffer (NUM_WARPS=4, DEPTH=2, DATAW=128).
module tb_vx_warp_ibuffer;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [1:0]   in_wid;
    logic [127:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [1:0]   out_wid;
    logic [127:0] out_data;
    logic         out_ready;
    logic         flush_valid;
    logic [1:0]   flush_wid;
    logic [3:0]   empty_mask;

    int tests_run;
    int tests_failed;

    vx_warp_ibuffer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_wid     (in_wid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_wid    (out_wid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .flush_valid(flush_valid),
        .flush_wid  (flush_wid),
        .empty_mask (empty_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; checks happen 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        in_wid      = 2'd0;
        in_data     = '0;
        out_ready   = 1'b0;
        flush_valid = 1'b0;
        flush_wid   = 2'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        #12;
        reset = 1'b1;
        tick();
    endtask

    task automatic push_one(input logic [1:0] wid, input logic [127:0] data);
        in_valid = 1'b1;
        in_wid   = wid;
        in_data  = data;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        tests_run++;
        if (empty_mask !== 4'b1111) begin
            tests_failed++;
            $display("[TB] FAIL reset_empty_mask: got %b expected 1111", empty_mask);
        end
        tests_run++;
        if (out_wid !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_out_wid: got %0d expected 0", out_wid);
        end
        reset = 1'b1;
        tick();
        push_one(2'd0, 128'hA0);
        push_one(2'd1, 128'hA1);
        push_one(2'd2, 128'hA2);
        #1;
        tests_run++;
        if (empty_mask !== 4'b1000) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_empty_mask: got %b expected 1000", empty_mask);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_out_valid: got %b expected 0", out_valid);
        end
        tests_run++;
        if (empty_mask !== 4'b1111) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_empty_mask: got %b expected 1111", empty_mask);
        end
        #10;
        reset = 1'b1;
        tick();
        in_wid = 2'd1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_out_valid: got %b expected 0", out_valid);
        end
        tests_run++;
        if (empty_mask !== 4'b1111) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_empty_mask: got %b expected 1111", empty_mask);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_fill_full();
        do_reset();
        push_one(2'd1, 128'h1111_0001);
        push_one(2'd1, 128'h1111_0002);
        in_valid = 1'b1;
        in_wid   = 2'd1;
        in_data  = 128'h1111_0003;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL full_in_ready: got %b expected 0", in_ready);
        end
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_wid !== 2'd1 || out_data !== 128'h1111_0001) begin
                tests_failed++;
                $display("[TB] FAIL full_stable_c%0d: got v=%b w=%0d d=%h expected v=1 w=1 d=11110001",
                         c, out_valid, out_wid, out_data);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (out_data !== 128'h1111_0001) begin
            tests_failed++;
            $display("[TB] FAIL drain_first: got %h expected 11110001", out_data);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 128'h1111_0002) begin
            tests_failed++;
            $display("[TB] FAIL drain_second: got v=%b d=%h expected v=1 d=11110002", out_valid, out_data);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || empty_mask !== 4'b1111) begin
            tests_failed++;
            $display("[TB] FAIL drain_empty: got v=%b e=%b expected v=0 e=1111", out_valid, empty_mask);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_wid [3];
        exp_wid[0] = 2'd0;
        exp_wid[1] = 2'd2;
        exp_wid[2] = 2'd3;
        do_reset();
        push_one(2'd0, 128'hD0);
        push_one(2'd2, 128'hD2);
        push_one(2'd3, 128'hD3);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if (out_valid !== 1'b1 || out_wid !== exp_wid[k] ||
                out_data !== {120'd0, 4'hD, 2'b00, exp_wid[k]}) begin
                tests_failed++;
                $display("[TB] FAIL rr_pop%0d: got v=%b w=%0d d=%h expected w=%0d",
                         k, out_valid, out_wid, out_data, exp_wid[k]);
            end
            tick();
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rr_drained: got %b expected 0", out_valid);
        end
        tests_run++;
        if (dut.rr_ptr !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL rr_ptr_wrap: got %0d expected 0", dut.rr_ptr);
        end
        out_ready = 1'b0;
        push_one(2'd0, 128'hE0);
        push_one(2'd1, 128'hE1);
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (out_wid !== 2'd0 || out_data !== 128'hE0) begin
            tests_failed++;
            $display("[TB] FAIL rr_second_a: got w=%0d d=%h expected w=0 d=e0", out_wid, out_data);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_wid !== 2'd1 || out_data !== 128'hE1) begin
            tests_failed++;
            $display("[TB] FAIL rr_second_b: got v=%b w=%0d d=%h expected v=1 w=1 d=e1",
                     out_valid, out_wid, out_data);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_hold();
        do_reset();
        push_one(2'd2, 128'hB2);
        push_one(2'd0, 128'hB0);
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_wid !== 2'd2 || out_data !== 128'hB2) begin
                tests_failed++;
                $display("[TB] FAIL hold_c%0d: got v=%b w=%0d d=%h expected v=1 w=2 d=b2",
                         c, out_valid, out_wid, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (out_wid !== 2'd2) begin
            tests_failed++;
            $display("[TB] FAIL hold_release: got w=%0d expected 2", out_wid);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_wid !== 2'd0 || out_data !== 128'hB0) begin
            tests_failed++;
            $display("[TB] FAIL hold_next: got v=%b w=%0d d=%h expected v=1 w=0 d=b0",
                     out_valid, out_wid, out_data);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        push_one(2'd1, 128'hF0);
        push_one(2'd1, 128'hF1);
        out_ready   = 1'b1;
        flush_valid = 1'b1;
        flush_wid   = 2'd1;
        in_valid    = 1'b1;
        in_wid      = 2'd1;
        in_data     = 128'hBAD;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_push_refused: got %b expected 0", in_ready);
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_no_pop: got %b expected 0", out_valid);
        end
        in_wid  = 2'd3;
        in_data = 128'hC3;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL flush_other_push: got %b expected 1", in_ready);
        end
        tick();
        in_valid    = 1'b0;
        flush_valid = 1'b0;
        #1;
        tests_run++;
        if (empty_mask !== 4'b0111) begin
            tests_failed++;
            $display("[TB] FAIL flush_empty_mask: got %b expected 0111", empty_mask);
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_wid !== 2'd3 || out_data !== 128'hC3) begin
            tests_failed++;
            $display("[TB] FAIL flush_other_out: got v=%b w=%0d d=%h expected v=1 w=3 d=c3",
                     out_valid, out_wid, out_data);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || empty_mask !== 4'b1111) begin
            tests_failed++;
            $display("[TB] FAIL flush_final: got v=%b e=%b expected v=0 e=1111", out_valid, empty_mask);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_streaming();
        logic [127:0] payload [10];
        for (int i = 0; i < 10; i++) begin
            payload[i] = {4{32'h5A00_0000 + 32'(i)}};
        end
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_wid   = 2'd0;
            in_data  = payload[i];
            #1;
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL stream_in_ready_%0d: got %b expected 1", i, in_ready);
            end
            if (i == 0) begin
                tests_run++;
                if (out_valid !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_first_idle: got %b expected 0", out_valid);
                end
            end else begin
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== payload[i-1]) begin
                    tests_failed++;
                    $display("[TB] FAIL stream_out_%0d: got v=%b d=%h expected v=1 d=%h",
                             i - 1, out_valid, out_data, payload[i-1]);
                end
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== payload[9]) begin
            tests_failed++;
            $display("[TB] FAIL stream_out_9: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, payload[9]);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || empty_mask !== 4'b1111) begin
            tests_failed++;
            $display("[TB] FAIL stream_drained: got v=%b e=%b expected v=0 e=1111", out_valid, empty_mask);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        idle_inputs();
        reset = 1'b0;
        #12;
        test_reset();
        test_fill_full();
        test_round_robin();
        test_hold();
        test_flush();
        test_streaming();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/vx_warp_ibuffer.md
# vx_warp_ibuffer

Per-warp instruction buffer between the decode stage and the issue/scoreboard stage. Accepts one decoded instruction per cycle tagged with its warp ID and stores it in that warp's FIFO. Presents at most one instruction per cycle downstream, chosen round-robin among warps with buffered instructions. Supports a per-warp flush for branch/warp-control redirects.

## Interface

- `NUM_WARPS`, default 4: warp count; power of 2, at least 2.
- `DEPTH`, default 2: entries per warp FIFO; power of 2, at least 2.
- `DATAW`, default 128: width of the packed decoded-instruction payload (ex_type, op_type, op_mod, wb, use_PC, use_imm, imm, rd, rs1..rs3, PC, tmask, uuid), treated as opaque.
- `WIDW`: derived, `$clog2(NUM_WARPS)`.

Ports:
- `clk` in, 1: clock. The block uses one clock.
- `reset` in, 1: asynchronous, active-low reset.
- `in_valid` in, 1: decoded instruction valid.
- `in_wid` in, WIDW: warp ID of the incoming instruction.
- `in_data` in, DATAW: decoded payload.
- `in_ready` out, 1: equals `!full[in_wid] && !(flush_valid && flush_wid == in_wid)`.
- `out_valid` out, 1: an instruction is presented.
- `out_wid` out, WIDW: warp of the presented instruction.
- `out_data` out, DATAW: head entry of that warp.
- `out_ready` in, 1: downstream accepts.
- `flush_valid` in, 1: flush request.
- `flush_wid` in, WIDW: warp to flush.
- `empty_mask` out, NUM_WARPS: bit w set when warp w's FIFO is empty. Feeds the warp scheduler.

## Operation

- **Per-warp FIFO state:** `wr_ptr`, `rd_ptr` (`log2(DEPTH)` bits, natural wrap), and `count` (`log2(DEPTH)+1` bits). Full means `count == DEPTH`; empty means `count == 0`.
- **Push:** happens when `in_valid && in_ready`. Writes `in_data` at `wr_ptr[in_wid]`, increments `wr_ptr` and `count`.
- **Pop:** happens when `out_valid && out_ready`. Increments `rd_ptr[out_wid]` and decrements `count`.
- **Simultaneous push and pop on the same warp:** `count` is unchanged and both pointers advance.
- **No push-to-pop bypass.** `in_ready` ignores a same-cycle pop, so a full warp refuses input even if it is being popped.
- **Arbitration:**
  - `rr_ptr` (WIDW bits) selects the starting index.
  - The grant is the first non-empty, non-flushed warp scanning `rr_ptr`, `rr_ptr+1`, ... modulo NUM_WARPS.
  - On pop, `rr_ptr <= out_wid + 1` (mod NUM_WARPS).
- **Hold rule:**
  - If `out_valid && !out_ready`, the grant is latched (`hold=1`, `held_wid`).
  - The next cycle presents the same warp and the same `out_data`, even if another warp becomes eligible.
  - Hold clears on pop, or when `held_wid` is flushed.
- **Flush:**
  - On `flush_valid`, warp `flush_wid` has `count`, `wr_ptr` and `rd_ptr` cleared at the clock edge.
  - That cycle, the flushed warp is excluded from arbitration, so no pop of it occurs.
  - A push to the flushed warp is refused via `in_ready=0`.
  - Pushes and pops on other warps proceed normally.
- **Storage:** a flop array of `NUM_WARPS*DEPTH*DATAW` bits. It is not reset; contents are don't-care while empty.

## Timing

- **Reset values (asserted asynchronously):**
  - All `count`, `wr_ptr`, `rd_ptr`, `rr_ptr` = 0; `hold` = 0.
  - `out_valid` = 0, `out_wid` = 0, `empty_mask` = all ones.
  - `in_ready` = 1 for any `in_wid`.
- **Reset mid-operation** discards all buffered instructions. No pop is reported.
- **Latency:**
  - An instruction pushed at edge N is eligible at edge N, so it can first appear on `out_valid` in cycle N+1. Minimum latency is one cycle.
  - Throughput is one push and one pop per cycle.
- `empty_mask`, `in_ready`, `out_valid`, `out_wid` and `out_data` are combinational from registered state plus `flush_*` and `in_wid`. There are no combinational paths from `out_ready` to `out_*`, or from `in_valid` to `in_ready`.
- **Handshake rules:**
  - Once asserted, `out_valid` stays high, with `out_wid` and `out_data` stable, until `out_ready` or a flush of `held_wid`.
  - `in_valid` may drop without handshake, because the upstream decode stage holds its data.
- **Wrap-around:** pointers wrap naturally at DEPTH. `rr_ptr` wraps from NUM_WARPS-1 to 0.

## Test plan

- **Reset:** assert `reset`=0 mid-stream with 3 entries buffered, release -> `out_valid`=0, `empty_mask`=4'b1111, `in_ready`=1.
- **Fill/full:** push 2 instructions to wid 1 (DEPTH=2) with `out_ready`=0 -> third push sees `in_ready`=0. `out_data` equals the first payload and stays stable for 5 cycles.
- **Round-robin:** one entry each in wids 0, 2, 3 with `out_ready`=1 -> pops in order wid 0, 2, 3 on consecutive cycles, `rr_ptr` ending at 0. Then push wid 1 and wid 0 together-queued -> wid 0 is served before wid 1.
- **Hold:** wid 2 presented with `out_ready`=0, then push to wid 0 -> `out_wid` stays 2 until `out_ready`=1, then wid 0 follows next cycle.
- **Flush:**
  - Wid 1 holds 2 entries and is presented with `out_ready`=1; `flush_valid`=1, `flush_wid`=1 -> no pop of wid 1, and `empty_mask[1]`=1 the next cycle.
  - A same-cycle push to wid 1 sees `in_ready`=0.
  - A same-cycle push to wid 3 is accepted.
- **Streaming/wrap:** continuous push and pop on wid 0 for 10 cycles -> 10 payloads out in order with 1-cycle latency. `count` stays at 1 or below and pointers wrap without loss.
